// File: rtl/batch_sequencer_pkg.sv
// rtl/batch_sequencer_pkg.sv - shared types for the batch sequencer
package batch_sequencer_pkg;

  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

endpackage

// File: rtl/sample_bank_ram.sv
// rtl/sample_bank_ram.sv - two-bank sample regfile, one write port, one registered read port
module sample_bank_ram #(
  parameter int N     = 3,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     wbank,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [N-1:0]             wdata,
  input  logic                     re,
  input  logic                     rbank,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [N-1:0]             rdata
);

  logic [N-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[rbank][raddr];
  end

endmodule

// File: rtl/batch_sequencer.sv
// rtl/batch_sequencer.sv - ping-pong capture, in-order forward and reversed backward replay
// Optional drop-on-full write guard and sticky overrun flag: BATCH_SEQ_OVERRUN_EN
module batch_sequencer #(
  parameter int N     = 3,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic [N-1:0] fwd_sel,
  output logic         fwd_valid,
  output logic [N-1:0] bwd_sel,
  output logic         bwd_valid,
  output logic         bwd_clear,
  output logic         bwd_last,
  output logic         busy,
  output logic         overrun
);
  import batch_sequencer_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  seq_state_t    state;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          wbank;
  logic          rbank;
  logic [1:0]    full;
  logic          release_rd;
  logic          wr_en;
  logic          wr_last;

  // Reader frees its bank on the oldest-sample read; a writer waiting on that bank may use it now.
  assign release_rd = (state == SEQ_RUN) && (raddr == '0);

`ifdef BATCH_SEQ_OVERRUN_EN
  logic wbank_free;
  assign wbank_free = !full[wbank] || (release_rd && (rbank == wbank));
  assign wr_en      = in_valid && wbank_free;

  always_ff @(posedge clk) begin
    if (rst)                         overrun <= 1'b0;
    else if (in_valid && !wbank_free) overrun <= 1'b1;
  end
`else
  assign wr_en   = in_valid;
  assign overrun = 1'b0;
`endif

  assign wr_last = wr_en && (waddr == ADDR_MAX);
  assign busy    = (state == SEQ_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel   <= '0;
      fwd_valid <= 1'b0;
    end else begin
      fwd_sel   <= in;
      fwd_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr <= '0;
      wbank <= 1'b0;
    end else if (wr_en) begin
      if (wr_last) begin
        waddr <= '0;
        wbank <= ~wbank;
      end else begin
        waddr <= waddr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (release_rd) full[rbank] <= 1'b0;
      if (wr_last)    full[wbank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      raddr     <= '0;
      rbank     <= 1'b0;
      bwd_valid <= 1'b0;
      bwd_clear <= 1'b0;
      bwd_last  <= 1'b0;
    end else begin
      bwd_valid <= 1'b0;
      bwd_clear <= 1'b0;
      bwd_last  <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (full[rbank]) begin
            state <= SEQ_RUN;
            raddr <= ADDR_MAX;
          end
        end
        SEQ_RUN: begin
          bwd_valid <= 1'b1;
          bwd_clear <= (raddr == ADDR_MAX);
          bwd_last  <= (raddr == '0);
          raddr     <= raddr - 1'b1;
          if (raddr == '0) begin
            rbank <= ~rbank;
            if (!full[~rbank]) state <= SEQ_IDLE;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  sample_bank_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .wbank (wbank),
    .waddr (waddr),
    .wdata (in),
    .re    (state == SEQ_RUN),
    .rbank (rbank),
    .raddr (raddr),
    .rdata (bwd_sel)
  );

endmodule
